// File: rtl/logic_unit.sv
// Registered WIDTH-bit bitwise logic unit with a one-deep valid/ready output stage.
// Flags track the stored result; an accumulate mode reuses that result as operand B.
module logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_out,
  output logic             parity_out,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] fn_res;
  logic             accept;
  logic             consume;

  // The output stage frees up when it is empty or being drained this edge.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = valid_q && out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fn_res = '0;
    b_eff  = acc_en ? result_q : b;
    unique case (op_e'(op))
      OP_AND:  fn_res = a & b_eff;
      OP_OR:   fn_res = a | b_eff;
      OP_NOTA: fn_res = ~a;
      OP_NAND: fn_res = ~(a & b_eff);
      OP_NOR:  fn_res = ~(a | b_eff);
      OP_XOR:  fn_res = a ^ b_eff;
      OP_XNOR: fn_res = ~(a ^ b_eff);
      OP_PASS: fn_res = a;
      default: fn_res = '0;
    endcase
  end

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (accept) begin
      result_d = fn_res;
      zero_d   = (fn_res == '0);
      parity_d = ^fn_res;
      valid_d  = 1'b1;
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
    end else if (consume) begin
      // Result and flags are kept so accumulate can still chain from them.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign result     = result_q;
  assign zero_out   = zero_q;
  assign parity_out = parity_q;
  assign out_valid  = valid_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit: a transaction-level model checked every cycle,
// plus directed vectors with literal expected values.
module tb_logic_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_out;
  logic             parity_out;
  logic [CNT_W-1:0] op_count;

  int total = 0;
  int bad   = 0;

  logic_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .acc_en     (acc_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_out   (zero_out),
    .parity_out (parity_out),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what the block must hold after each edge.
  function automatic logic [WIDTH-1:0] apply_op(input int o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    case (o)
      0: return x & y;
      1: return x | y;
      2: return ~x;
      3: return ~(x & y);
      4: return ~(x | y);
      5: return x ^ y;
      6: return ~(x ^ y);
      default: return x;
    endcase
  endfunction

  logic [WIDTH-1:0] m_result;
  logic             m_valid;
  int               m_count;
  bit               chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_result = '0;
      m_valid  = 1'b0;
      m_count  = 0;
      chk_en   = 1'b1;
    end else if (chk_en) begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_result = apply_op(int'(op), a, acc_en ? m_result : b);
        m_valid  = 1'b1;
        m_count  = (m_count + 1 > 15) ? 15 : m_count + 1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_out_valid", out_valid, m_valid);
      check("mdl_in_ready", in_ready, !m_valid || out_ready);
      check("mdl_op_count", op_count, m_count);
      check("mdl_result", result, m_result);
      check("mdl_zero", zero_out, m_result == '0);
      check("mdl_parity", parity_out, $countones(m_result) % 2);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] exp_ops [8];

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; acc_en = 1'b0; out_ready = 1'b0;
    exp_ops = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};

    // 1. reset then idle
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("rst_result", result, 8'h00);
    check("rst_zero", zero_out, 1'b1);
    check("rst_parity", parity_out, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_op_count", op_count, 0);

    // 2. every op, full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; a = 8'hF0; b = 8'h3C; op = 3'(i);
      cyc();
      check($sformatf("op%0d_result", i), result, exp_ops[i]);
      check($sformatf("op%0d_parity", i), parity_out, 1'b0);
      check($sformatf("op%0d_valid", i), out_valid, 1'b1);
    end
    in_valid = 1'b0;
    cyc();
    check("ops_count", op_count, 8);
    check("ops_drained", out_valid, 1'b0);

    // 3. backpressure
    in_valid = 1'b1; a = 8'hAA; b = 8'h55; op = 3'd5; out_ready = 1'b0;
    cyc();
    a = 8'h11; b = 8'h22; op = 3'd1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp%0d_result", i), result, 8'hFF);
      check($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
      cyc();
    end
    check("bp_hold_result", result, 8'hFF);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1'b1);
    cyc();
    check("bp_new_result", result, 8'h33);
    check("bp_valid_kept", out_valid, 1'b1);
    check("bp_count", op_count, 10);
    in_valid = 1'b0;
    cyc();

    // 4. accumulate
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    in_valid = 1'b1; acc_en = 1'b1; op = 3'd1; b = 8'hFF;
    a = 8'h01; cyc(); check("acc1", result, 8'h01);
    a = 8'h02; cyc(); check("acc2", result, 8'h03);
    a = 8'h80; cyc(); check("acc3", result, 8'h83);
    check("acc3_parity", parity_out, 1'b1);
    op = 3'd0; a = 8'h0F; cyc(); check("acc_and", result, 8'h03);
    in_valid = 1'b0; acc_en = 1'b0;
    cyc();

    // 5. saturation
    in_valid = 1'b1; op = 3'd7;
    for (int i = 0; i < 20; i++) begin
      a = 8'(i);
      cyc();
    end
    check("sat_count", op_count, 15);
    cyc(); cyc();
    check("sat_hold", op_count, 15);
    in_valid = 1'b0;
    cyc();

    // 6. reset while stalled
    in_valid = 1'b1; a = 8'h5A; op = 3'd7; out_ready = 1'b0;
    cyc(); cyc();
    check("stall_valid", out_valid, 1'b1);
    check("stall_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_result", result, 8'h00);
    check("mid_rst_count", op_count, 0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit.md
Name: logic_unit

Overview:
- Parametrised, registered successor to the two-input single-bit gate bank.
- Applies one of eight bitwise operations, selected per transaction by an opcode, to WIDTH-bit operands.
- Returns the result through a one-deep output register with a valid/ready handshake, plus zero and parity flags.
- An accumulate mode feeds the previous result back as operand B, so chained bitwise reductions need no external loop.
- Sits between a producer (register file or sequencer) and any consumer that can apply backpressure.

Parameters:
- WIDTH, 8: operand and result width in bits; minimum 1.
- CNT_W, 16: width of the transaction counter op_count.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: producer presents a, b, op and acc_en.
- in_ready, output, 1: block can accept this cycle.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B; ignored when acc_en=1.
- op, input, 3: operation select.
- acc_en, input, 1: use the stored result as operand B.
- out_valid, output, 1: result, zero_out and parity_out are valid.
- out_ready, input, 1: consumer accepts the result.
- result, output, WIDTH: registered operation result.
- zero_out, output, 1: registered; 1 when the result is all zeros.
- parity_out, output, 1: registered XOR-reduction of the result.
- op_count, output, CNT_W: saturating count of accepted transactions.

Behaviour:
- Reset (rst=1 at a clock edge): result=0, zero_out=1, parity_out=0, out_valid=0, op_count=0.
  - Reset has priority over every other event.
  - A pending, unconsumed result is discarded.
- op encoding, bitwise over WIDTH, with B_eff = acc_en ? result : b:
  - 0 AND, 1 OR, 2 NOT A (B ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS A.
- in_ready = !out_valid | out_ready. This is combinational, with no path from in_valid.
- Accept means in_valid & in_ready at a rising edge.
  - On accept, result, zero_out and parity_out load from the function of the sampled inputs, and out_valid becomes 1.
  - Latency is 1 cycle: the result is visible the cycle after accept.
- Consume means out_valid & out_ready at a rising edge.
- Consume without accept: out_valid becomes 0.
  - result, zero_out and parity_out hold their values; the result stays available for accumulate.
- Consume and accept in the same edge: the new result loads and out_valid stays 1, giving full throughput of one op per cycle.
- Stall (out_valid=1 and out_ready=0):
  - in_ready=0.
  - result, zero_out, parity_out and out_valid must not change.
  - Inputs are not sampled.
- Accumulate mode: B_eff is the result register value at the accept edge. This is either the last produced value, whether or not it was consumed, or 0 after reset.
- op_count increments by 1 on each accept and saturates at 2^CNT_W-1 with no wrap. rst is the only way to clear it.
- Outputs are pure registers; no combinational path exists from a, b or op to result.
- in_valid=1 while in_ready=0 causes no state change. The producer holds its inputs, per the usual valid/ready rule.

Test Plan (WIDTH=8, CNT_W=4):
1. Reset, then idle → result=0x00, zero_out=1, parity_out=0, out_valid=0, in_ready=1, op_count=0.
2. Each op 0..7 with a=0xF0, b=0x3C and out_ready=1 → result is 0x30, 0xFC, 0x0F, 0xCF, 0x03, 0xCC, 0x33, 0xF0 respectively, each one cycle after accept. parity_out is 0 for all eight. op_count=8.
3. Backpressure: accept a=0xAA, b=0x55, op=5, then hold out_ready=0 for 3 cycles with new inputs presented.
   - result stays 0xFF and in_ready stays 0 throughout.
   - On out_ready=1, the new input is accepted in the same edge and out_valid stays 1.
4. Accumulate: after reset, send op=1 with a=0x01, a=0x02, a=0x80, all with acc_en=1 → results 0x01, 0x03, 0x83; parity_out=1 on the last.
   - Then op=0 with a=0x0F, acc_en=1 → result 0x03.
5. Saturation: perform 20 accepts → op_count=15 and remains 15.
6. Reset mid-stall: with out_valid=1 and out_ready=0, assert rst for 1 cycle → next cycle out_valid=0, result=0x00, op_count=0, in_ready=1.
